div_seq: RTL and testbench

Multi-cycle sequencer for the RV32M divide/remainder ops (DIV, DIVU, REM, REMU) in the single-cycle core. The ALU covers every other `alu_op_e` value in one cycle; divides are routed here instead. The block runs a radix-2 restoring divider over XLEN iterations and stalls the core until the result is ready. It sits beside the ALU, takes `alu_op` from ALU control and the register operands, and drives the writeback mux on `done`.

---
 rtl/div_seq_pkg.sv | 51 +++++
 rtl/div_seq_core.sv | 79 +++++++
 rtl/div_seq.sv | 166 ++++++++++++++++
 tb/tb_div_seq.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/div_seq_pkg.sv
// Shared ALU definitions for the single-cycle core plus the divider
// sequencer's state type and op-classification helpers.
//   alu_op_e    : ALU control op encoding
//   div_state_e : divider sequencer states
//   is_div      : op is one of DIV/DIVU/REM/REMU
//   is_div_signed / is_div_rem : op sub-classification for the sequencer
package div_seq_pkg;

  typedef enum logic [4:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_LUI,
    ALU_MUL,
    ALU_MULH,
    ALU_MULHSU,
    ALU_MULHU,
    ALU_DIV,
    ALU_DIVU,
    ALU_REM,
    ALU_REMU
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } div_state_e;

  function automatic logic is_div(input alu_op_e op);
    return (op == ALU_DIV) || (op == ALU_DIVU) ||
           (op == ALU_REM) || (op == ALU_REMU);
  endfunction

  function automatic logic is_div_signed(input alu_op_e op);
    return (op == ALU_DIV) || (op == ALU_REM);
  endfunction

  function automatic logic is_div_rem(input alu_op_e op);
    return (op == ALU_REM) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/div_seq_core.sv
// Radix-2 restoring shift-subtract datapath for unsigned division.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture dividend/divisor, clear remainder, counter = XLEN
//   step       : perform one restoring iteration, decrement counter
//   dividend   : unsigned dividend (magnitude)
//   divisor    : unsigned divisor (magnitude)
//   quotient   : quotient bits (valid after XLEN steps)
//   remainder  : partial / final remainder
//   count      : iterations still to perform
module div_core #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [XLEN-1:0]  dividend,
  input  logic [XLEN-1:0]  divisor,
  output logic [XLEN-1:0]  quotient,
  output logic [XLEN-1:0]  remainder,
  output logic [CNT_W-1:0] count
);

  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  dvd_q, dvd_d;
  logic [XLEN-1:0]  dvsr_q, dvsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  // The partial remainder is always below the divisor, so the shifted value
  // stays under 2*divisor and the MSB of the XLEN+1 bit difference is a
  // reliable borrow flag.
  assign shifted = {rem_q, dvd_q[XLEN-1]};
  assign trial   = shifted - {1'b0, dvsr_q};

  always_comb begin
    rem_d  = rem_q;
    dvd_d  = dvd_q;
    dvsr_d = dvsr_q;
    cnt_d  = cnt_q;
    if (load) begin
      rem_d  = '0;
      dvd_d  = dividend;
      dvsr_d = divisor;
      cnt_d  = CNT_W'(XLEN);
    end else if (step) begin
      if (!trial[XLEN]) begin
        rem_d = trial[XLEN-1:0];
        dvd_d = {dvd_q[XLEN-2:0], 1'b1};
      end else begin
        rem_d = shifted[XLEN-1:0];
        dvd_d = {dvd_q[XLEN-2:0], 1'b0};
      end
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      dvd_q  <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
    end else begin
      rem_q  <= rem_d;
      dvd_q  <= dvd_d;
      dvsr_q <= dvsr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign quotient  = dvd_q;
  assign remainder = rem_q;
  assign count     = cnt_q;

endmodule

// File: rtl/div_seq.sv
// Multi-cycle RV32M divide/remainder sequencer (DIV, DIVU, REM, REMU).
// Stalls the core while a restoring divide runs, then presents the result
// for one cycle with done.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : M-group R-type instruction present (held while stall=1)
//   alu_op     : op from ALU control; only divide ops are acted on
//   op_a, op_b : dividend (rs1), divisor (rs2)
//   flush      : abort any operation in flight
//   stall      : freeze PC / suppress register-file write
//   busy       : sequencer not idle
//   done       : one-cycle result valid
//   result     : quotient or remainder, held until the next completion
module div_seq
  import div_seq_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  alu_op_e         alu_op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      state_q, state_d;
  alu_op_e         op_q, op_d;
  logic            sign_quo_q, sign_quo_d;
  logic            sign_rem_q, sign_rem_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            req;
  logic            signed_req;
  logic [XLEN-1:0] a_abs, b_abs;
  logic            div_by_zero, overflow;
  logic [XLEN-1:0] special_res;
  logic [XLEN-1:0] fix_res;

  logic             core_load, core_step;
  logic [XLEN-1:0]  core_quo, core_rem;
  logic [CNT_W-1:0] core_cnt;

  assign req        = start && is_div(alu_op);
  assign signed_req = is_div_signed(alu_op);

  // Negating the most negative value wraps back to itself, which is exactly
  // its magnitude when read as unsigned.
  assign a_abs = (signed_req && op_a[XLEN-1]) ? -op_a : op_a;
  assign b_abs = (signed_req && op_b[XLEN-1]) ? -op_b : op_b;

  assign div_by_zero = (op_b == '0);
  assign overflow    = signed_req && (op_a == MIN_NEG) && (op_b == '1);

  always_comb begin
    special_res = '0;
    if (div_by_zero) begin
      special_res = is_div_rem(alu_op) ? op_a : '1;
    end else if (overflow) begin
      special_res = is_div_rem(alu_op) ? '0 : MIN_NEG;
    end
  end

  always_comb begin
    fix_res = '0;
    if (is_div_rem(op_q)) begin
      fix_res = (is_div_signed(op_q) && sign_rem_q) ? -core_rem : core_rem;
    end else begin
      fix_res = (is_div_signed(op_q) && sign_quo_q) ? -core_quo : core_quo;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    sign_quo_d = sign_quo_q;
    sign_rem_d = sign_rem_q;
    result_d   = result_q;
    core_load  = 1'b0;
    core_step  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (div_by_zero || overflow) begin
            result_d = special_res;
            state_d  = DONE;
          end else begin
            core_load  = 1'b1;
            op_d       = alu_op;
            sign_quo_d = op_a[XLEN-1] ^ op_b[XLEN-1];
            sign_rem_d = op_a[XLEN-1];
            state_d    = RUN;
          end
        end
      end
      RUN: begin
        core_step = 1'b1;
        if (core_cnt == CNT_W'(1)) state_d = FIX;
      end
      FIX: begin
        result_d = fix_res;
        state_d  = DONE;
      end
      DONE: begin
        // start is still high for the retiring instruction; returning to
        // IDLE unconditionally is what prevents a re-trigger.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d    = IDLE;
      op_d       = op_q;
      sign_quo_d = sign_quo_q;
      sign_rem_d = sign_rem_q;
      result_d   = result_q;
      core_load  = 1'b0;
      core_step  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= ALU_ADD;
      sign_quo_q <= 1'b0;
      sign_rem_q <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      sign_quo_q <= sign_quo_d;
      sign_rem_q <= sign_rem_d;
      result_q   <= result_d;
    end
  end

  div_core #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_div_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (core_load),
    .step      (core_step),
    .dividend  (a_abs),
    .divisor   (b_abs),
    .quotient  (core_quo),
    .remainder (core_rem),
    .count     (core_cnt)
  );

  assign stall  = ((state_q == IDLE) && req && !flush) ||
                  (state_q == RUN) || (state_q == FIX);
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq (XLEN=32).
module tb_div_seq;
  import div_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  alu_op_e     alu_op;
  logic [31:0] op_a, op_b;
  logic        flush;
  logic        stall, busy, done;
  logic [31:0] result;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned done_cnt = 0;

  div_seq #(
    .XLEN (32)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .alu_op (alu_op),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Presents a request at cycle T and follows it to done. start is left
  // high so a following call exercises back-to-back issue.
  task automatic run_div(input string tag, input alu_op_e op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat);
    int cyc;
    bit stall_ok;
    bit seen;
    @(posedge clk); #1;
    start = 1'b1; alu_op = op; op_a = a; op_b = b; flush = 1'b0;
    #1;
    chk({tag, "_stall_T"}, 32'(stall), 32'd1);
    chk({tag, "_busy_T"}, 32'(busy), 32'd0);
    cyc = 0; stall_ok = 1'b1; seen = 1'b0;
    while (!seen && cyc < 60) begin
      @(posedge clk); #2;
      cyc++;
      if (done) seen = 1'b1;
      else if (!stall) stall_ok = 1'b0;
    end
    chk({tag, "_done"}, 32'(seen), 32'd1);
    chk({tag, "_lat"}, 32'(cyc), 32'(lat));
    chk({tag, "_stall_win"}, 32'(stall_ok), 32'd1);
    chk({tag, "_stall_done"}, 32'(stall), 32'd0);
    chk({tag, "_result"}, result, exp);
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    start = 1'b0; alu_op = ALU_ADD; flush = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned dc0;
    bit ok;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; alu_op = ALU_ADD;
    op_a = '0; op_b = '0;
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Normal divides: done at T+34.
    run_div("divu_100_7", ALU_DIVU, 32'd100, 32'd7, 32'd14, 34);         idle(1);
    run_div("remu_100_7", ALU_REMU, 32'd100, 32'd7, 32'd2, 34);          idle(1);
    run_div("div_m7_2",   ALU_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34); idle(1);
    run_div("rem_m7_2",   ALU_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34); idle(1);
    run_div("div_7_m2",   ALU_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34); idle(1);
    run_div("div_min_2",  ALU_DIV,  32'h8000_0000, 32'd2, 32'hC000_0000, 34); idle(1);
    run_div("rem_min_3",  ALU_REM,  32'h8000_0000, 32'd3, 32'hFFFF_FFFE, 34); idle(1);
    run_div("divu_max_1", ALU_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34); idle(1);

    // Special cases: done at T+1.
    run_div("divu_5_0",   ALU_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);      idle(1);
    run_div("remu_5_0",   ALU_REMU, 32'd5, 32'd0, 32'd5, 1);              idle(1);
    run_div("div_ovf",    ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1); idle(1);
    run_div("rem_ovf",    ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);         idle(1);

    // Flush at T+10; result keeps the previous value (0 from rem_ovf).
    @(posedge clk); #1;
    start = 1'b1; alu_op = ALU_DIVU; op_a = 32'd1000; op_b = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b1;
    #1;
    chk("flush_stall_T10", 32'(stall), 32'd1);
    dc0 = done_cnt;
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    chk("flush_stall_T11", 32'(stall), 32'd0);
    chk("flush_busy_T11", 32'(busy), 32'd0);
    chk("flush_done_T11", 32'(done), 32'd0);
    chk("flush_result", result, 32'd0);
    repeat (5) @(posedge clk);
    chk("flush_no_done", done_cnt, dc0);
    run_div("divu_9_3", ALU_DIVU, 32'd9, 32'd3, 32'd3, 34); idle(1);

    // Asynchronous reset mid-RUN at T+5.
    @(posedge clk); #1;
    start = 1'b1; alu_op = ALU_DIVU; op_a = 32'd1000; op_b = 32'd3;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0; start = 1'b0;
    #1;
    chk("arst_stall", 32'(stall), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_result", result, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    start = 1'b1; alu_op = ALU_ADD; op_a = 32'd100; op_b = 32'd7;
    dc0 = done_cnt;
    ok = 1'b1;
    repeat (6) begin
      #2 if (stall || busy) ok = 1'b0;
      @(posedge clk);
    end
    #2;
    chk("add_no_stall", 32'(ok), 32'd1);
    chk("add_no_done", done_cnt, dc0);
    idle(1);

    // Back-to-back with start held through DONE.
    dc0 = done_cnt;
    run_div("b2b_first",  ALU_DIVU, 32'd100, 32'd7, 32'd14, 34);
    run_div("b2b_second", ALU_DIVU, 32'd200, 32'd9, 32'd22, 34);
    idle(3);
    chk("b2b_done_count", done_cnt - dc0, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
